cc_level_sequencer: RTL and testbench

CC_LEVEL_SEQUENCER -- requirements
Module: cc_level_sequencer

---
 rtl/cc_level_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cc_level_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_level_sequencer.sv
// Level sequencer: walks each level row by row, offers non-empty rows to the
// consumer, advances on road-scroll ticks and pauses between levels.
module cc_level_sequencer #(
  parameter int DATAWIDTH               = 8,
  parameter int CURRENTLEVEL_DATAWIDTH  = 3,
  parameter int LEVELPROGRESS_DATAWIDTH = 5,
  parameter int LVL1_LENGTH             = 10,
  parameter int LVL2_LENGTH             = 15,
  parameter int LVL3_LENGTH             = 20,
  parameter int PAUSE_TICKS             = 4
) (
  input  logic                               CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                               CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                               CC_LEVEL_SEQUENCER_Start_In,
  input  logic                               CC_LEVEL_SEQUENCER_Abort_In,
  input  logic                               CC_LEVEL_SEQUENCER_StepTick_In,
  input  logic                               CC_LEVEL_SEQUENCER_RowAck_In,
  input  logic [DATAWIDTH-1:0]               CC_LEVEL_SEQUENCER_LevelData_InBus,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LvlProgress_OutBus,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
  output logic [DATAWIDTH-1:0]               CC_LEVEL_SEQUENCER_RowData_OutBus,
  output logic                               CC_LEVEL_SEQUENCER_RowValid_Out,
  output logic                               CC_LEVEL_SEQUENCER_LevelDone_Out,
  output logic                               CC_LEVEL_SEQUENCER_GameDone_Out
);

  localparam int CW = CURRENTLEVEL_DATAWIDTH;
  localparam int LW = LEVELPROGRESS_DATAWIDTH;
  localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_OFFER = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_LDONE = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;
  localparam logic [2:0] S_GDONE = 3'd6;

  localparam logic [CW-1:0] LVL_1 = CW'(2);
  localparam logic [CW-1:0] LVL_2 = CW'(4);
  localparam logic [CW-1:0] LVL_3 = CW'(6);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 abort;
  logic                 tick;
  logic                 ack;
  logic [DATAWIDTH-1:0] data_in;

  logic [2:0]           state;
  logic [CW-1:0]        lvl;
  logic [LW-1:0]        prog;
  logic [DATAWIDTH-1:0] row_data;
  logic                 row_valid;
  logic                 level_done;
  logic                 game_done;
  logic                 pending;
  logic [PW-1:0]        pause_cnt;
  logic [LW-1:0]        lvl_len;

  assign clk     = CC_LEVEL_SEQUENCER_CLOCK_50;
  assign rst_n   = CC_LEVEL_SEQUENCER_RESET_InLow;
  assign start   = CC_LEVEL_SEQUENCER_Start_In;
  assign abort   = CC_LEVEL_SEQUENCER_Abort_In;
  assign tick    = CC_LEVEL_SEQUENCER_StepTick_In;
  assign ack     = CC_LEVEL_SEQUENCER_RowAck_In;
  assign data_in = CC_LEVEL_SEQUENCER_LevelData_InBus;

  assign CC_LEVEL_SEQUENCER_LvlProgress_OutBus = prog;
  assign CC_LEVEL_SEQUENCER_CurrentLvl_OutBus  = lvl;
  assign CC_LEVEL_SEQUENCER_RowData_OutBus     = row_data;
  assign CC_LEVEL_SEQUENCER_RowValid_Out       = row_valid;
  assign CC_LEVEL_SEQUENCER_LevelDone_Out      = level_done;
  assign CC_LEVEL_SEQUENCER_GameDone_Out       = game_done;

  always_comb begin
    lvl_len = LW'(LVL1_LENGTH);
    if (lvl == LVL_2)
      lvl_len = LW'(LVL2_LENGTH);
    else if (lvl == LVL_3)
      lvl_len = LW'(LVL3_LENGTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lvl        <= '0;
      prog       <= '0;
      row_data   <= '0;
      row_valid  <= 1'b0;
      level_done <= 1'b0;
      game_done  <= 1'b0;
      pending    <= 1'b0;
      pause_cnt  <= '0;
    end else if (abort) begin
      // Abort in IDLE is harmless: every register is already clear there.
      state      <= S_IDLE;
      lvl        <= '0;
      prog       <= '0;
      row_data   <= '0;
      row_valid  <= 1'b0;
      level_done <= 1'b0;
      game_done  <= 1'b0;
      pending    <= 1'b0;
      pause_cnt  <= '0;
    end else begin
      level_done <= 1'b0;
      case (state)
        S_IDLE, S_GDONE: begin
          row_valid <= 1'b0;
          if (start) begin
            lvl       <= LVL_1;
            prog      <= LW'(1);
            game_done <= 1'b0;
            pending   <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          row_data  <= data_in;
          row_valid <= |data_in;
          if (tick)
            pending <= 1'b1;
          state <= (|data_in) ? S_OFFER : S_WAIT;
        end
        S_OFFER: begin
          if (tick)
            pending <= 1'b1;
          if (ack) begin
            row_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tick || pending) begin
            pending <= 1'b0;
            if (prog < lvl_len) begin
              prog  <= prog + LW'(1);
              state <= S_FETCH;
            end else begin
              level_done <= 1'b1;
              state      <= S_LDONE;
            end
          end
        end
        S_LDONE: begin
          if (lvl == LVL_3) begin
            game_done <= 1'b1;
            state     <= S_GDONE;
          end else begin
            lvl       <= lvl + CW'(2);
            prog      <= LW'(1);
            pause_cnt <= '0;
            state     <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (tick) begin
            if (pause_cnt == PAUSE_LAST) begin
              pause_cnt <= '0;
              state     <= S_FETCH;
            end else begin
              pause_cnt <= pause_cnt + PW'(1);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          row_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Directed bench for cc_level_sequencer; the level data handler is modelled
// as row = 2*progress, with a switch to force empty rows.
module tb_cc_level_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tick = 1'b0;
  logic       ack = 1'b0;
  logic       zero_row = 1'b0;
  logic [7:0] row_in;
  logic [4:0] prog;
  logic [2:0] lvl;
  logic [7:0] row_data;
  logic       row_valid;
  logic       level_done;
  logic       game_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign row_in = zero_row ? 8'h00 : {2'b00, prog, 1'b0};

  always @(negedge clk)
    if (level_done === 1'b1)
      done_cnt++;

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50          (clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow       (rst_n),
    .CC_LEVEL_SEQUENCER_Start_In          (start),
    .CC_LEVEL_SEQUENCER_Abort_In          (abort),
    .CC_LEVEL_SEQUENCER_StepTick_In       (tick),
    .CC_LEVEL_SEQUENCER_RowAck_In         (ack),
    .CC_LEVEL_SEQUENCER_LevelData_InBus   (row_in),
    .CC_LEVEL_SEQUENCER_LvlProgress_OutBus(prog),
    .CC_LEVEL_SEQUENCER_CurrentLvl_OutBus (lvl),
    .CC_LEVEL_SEQUENCER_RowData_OutBus    (row_data),
    .CC_LEVEL_SEQUENCER_RowValid_Out      (row_valid),
    .CC_LEVEL_SEQUENCER_LevelDone_Out     (level_done),
    .CC_LEVEL_SEQUENCER_GameDone_Out      (game_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic a,
                     input logic t, input logic k);
    start = s;
    abort = a;
    tick  = t;
    ack   = k;
    step();
    start = 1'b0;
    abort = 1'b0;
    tick  = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // From FETCH: accept n rows, one tick each.
  task automatic play_rows(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    total++;
    if ({lvl, prog, row_data, row_valid, level_done, game_done} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got lvl=%0d prog=%0d data=%h v=%b ld=%b gd=%b want all 0",
               lvl, prog, row_data, row_valid, level_done, game_done);
    end
  endtask

  task automatic test_basic();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (lvl !== 3'd2 || prog !== 5'd1 || row_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_start got lvl=%0d prog=%0d v=%b want 2 1 0", lvl, prog, row_valid);
    end
    step();
    total++;
    if (row_valid !== 1'b1 || row_data !== 8'h02) begin
      bad++;
      $display("FAIL basic_offer got v=%b data=%h want 1 02", row_valid, row_data);
    end
    step();
    step();
    step();
    total++;
    if (row_valid !== 1'b1 || row_data !== 8'h02) begin
      bad++;
      $display("FAIL basic_hold got v=%b data=%h want 1 02", row_valid, row_data);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (row_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_ack got v=%b want 0", row_valid);
    end
  endtask

  task automatic test_level1();
    for (int p = 1; p <= 10; p++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      if (p < 10) begin
        total++;
        if (prog !== 5'(p + 1)) begin
          bad++;
          $display("FAIL l1_prog got %0d want %0d", prog, p + 1);
        end
        step();
        total++;
        if (row_valid !== 1'b1 || row_data !== 8'(2 * (p + 1))) begin
          bad++;
          $display("FAIL l1_row got v=%b data=%h want 1 %h",
                   row_valid, row_data, 8'(2 * (p + 1)));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        total++;
        if (level_done !== 1'b1 || prog !== 5'd10) begin
          bad++;
          $display("FAIL l1_done got ld=%b prog=%0d want 1 10", level_done, prog);
        end
      end
    end
    step();
    total++;
    if (level_done !== 1'b0 || lvl !== 3'd4 || prog !== 5'd1) begin
      bad++;
      $display("FAIL l1_next got ld=%b lvl=%0d prog=%0d want 0 4 1", level_done, lvl, prog);
    end
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    total++;
    if (row_valid !== 1'b0) begin
      bad++;
      $display("FAIL l1_pause3 got v=%b want 0", row_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    total++;
    if (row_valid !== 1'b1 || row_data !== 8'h02 || lvl !== 3'd4) begin
      bad++;
      $display("FAIL l1_pause4 got v=%b data=%h lvl=%0d want 1 02 4", row_valid, row_data, lvl);
    end
  endtask

  task automatic test_zero_row();
    do_reset();
    zero_row = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    zero_row = 1'b0;
    step();
    step();
    total++;
    if (row_valid !== 1'b0 || row_data !== 8'h00 || prog !== 5'd1) begin
      bad++;
      $display("FAIL zero_wait got v=%b data=%h prog=%0d want 0 00 1", row_valid, row_data, prog);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (prog !== 5'd2) begin
      bad++;
      $display("FAIL zero_adv got prog=%0d want 2", prog);
    end
    step();
    total++;
    if (row_valid !== 1'b1 || row_data !== 8'h04) begin
      bad++;
      $display("FAIL zero_next got v=%b data=%h want 1 04", row_valid, row_data);
    end
  endtask

  task automatic test_tick_offer();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (prog !== 5'd2 || row_valid !== 1'b1) begin
      bad++;
      $display("FAIL to_hold got prog=%0d v=%b want 2 1", prog, row_valid);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    total++;
    if (prog !== 5'd3) begin
      bad++;
      $display("FAIL to_pending got prog=%0d want 3", prog);
    end
    step();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    total++;
    if (prog !== 5'd3 || row_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_drop got prog=%0d v=%b want 3 0", prog, row_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (row_valid !== 1'b0 || prog !== 5'd4) begin
      bad++;
      $display("FAIL to_coinc got v=%b prog=%0d want 0 4", row_valid, prog);
    end
    step();
    total++;
    if (prog !== 5'd5) begin
      bad++;
      $display("FAIL to_first_wait got prog=%0d want 5", prog);
    end
  endtask

  task automatic test_full_game();
    int base;
    int lens[3] = '{10, 15, 20};
    do_reset();
    base = done_cnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int p = 1; p <= lens[l]; p++) begin
        step();
        total++;
        if (row_valid !== 1'b1 || prog !== 5'(p) || lvl !== 3'(2 * l + 2)) begin
          bad++;
          $display("FAIL game_row got v=%b prog=%0d lvl=%0d want 1 %0d %0d",
                   row_valid, prog, lvl, p, 2 * l + 2);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
      total++;
      if (level_done !== 1'b1) begin
        bad++;
        $display("FAIL game_ldone got %b want 1 (level %0d)", level_done, 2 * l + 2);
      end
      step();
      if (l < 2) begin
        for (int i = 0; i < 4; i++)
          cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    total++;
    if (game_done !== 1'b1 || lvl !== 3'd6 || row_valid !== 1'b0) begin
      bad++;
      $display("FAIL game_done got gd=%b lvl=%0d v=%b want 1 6 0", game_done, lvl, row_valid);
    end
    step();
    total++;
    if (done_cnt - base !== 3) begin
      bad++;
      $display("FAIL game_pulses got %0d want 3", done_cnt - base);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (game_done !== 1'b0 || lvl !== 3'd2 || prog !== 5'd1) begin
      bad++;
      $display("FAIL game_restart got gd=%b lvl=%0d prog=%0d want 0 2 1", game_done, lvl, prog);
    end
  endtask

  task automatic to_l2_p7();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    play_rows(10);
    step();
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    play_rows(6);
    step();
  endtask

  task automatic test_abort_reset();
    to_l2_p7();
    total++;
    if (lvl !== 3'd4 || prog !== 5'd7 || row_valid !== 1'b1 || row_data !== 8'h0e) begin
      bad++;
      $display("FAIL ab_setup got lvl=%0d prog=%0d v=%b data=%h want 4 7 1 0e",
               lvl, prog, row_valid, row_data);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if ({lvl, prog, row_data, row_valid, level_done, game_done} !== 19'd0) begin
      bad++;
      $display("FAIL ab_abort got lvl=%0d prog=%0d data=%h v=%b want all 0",
               lvl, prog, row_data, row_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    total++;
    if (lvl !== 3'd0 || row_valid !== 1'b0) begin
      bad++;
      $display("FAIL ab_idle got lvl=%0d v=%b want 0 0", lvl, row_valid);
    end
    to_l2_p7();
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    total++;
    if ({lvl, prog, row_data, row_valid, level_done, game_done} !== 19'd0) begin
      bad++;
      $display("FAIL ab_reset got lvl=%0d prog=%0d data=%h v=%b want all 0",
               lvl, prog, row_data, row_valid);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    play_rows(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (prog !== 5'd3 || row_valid !== 1'b1 || lvl !== 3'd2) begin
      bad++;
      $display("FAIL ab_start_fetch got prog=%0d v=%b lvl=%0d want 3 1 2", prog, row_valid, lvl);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (prog !== 5'd3 || row_valid !== 1'b1) begin
      bad++;
      $display("FAIL ab_start_offer got prog=%0d v=%b want 3 1", prog, row_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level1();
    test_zero_row();
    test_tick_offer();
    test_full_game();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
